// File: rtl/watch_pkg.sv
// Shared types and constants for the wristwatch time display.
// Segment patterns are {g,f,e,d,c,b,a}, active-low.
package watch_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] AN_D0  = 4'b1110;
  localparam logic [3:0] AN_D1  = 4'b1101;
  localparam logic [3:0] AN_D2  = 4'b1011;
  localparam logic [3:0] AN_D3  = 4'b0111;
  localparam logic [3:0] AN_OFF = 4'b1111;

  typedef enum logic [1:0] {
    IDLE,
    MIN,
    HR,
    DONE
  } conv_state_t;

  typedef struct packed {
    logic [3:0] hr_tens;
    logic [3:0] hr_ones;
    logic [3:0] min_tens;
    logic [3:0] min_ones;
  } bcd_t;

  function automatic logic [3:0] an_code(
    input logic [1:0] idx
  );
    case (idx)
      2'd0:    return AN_D0;
      2'd1:    return AN_D1;
      2'd2:    return AN_D2;
      default: return AN_D3;
    endcase
  endfunction

endpackage

// File: rtl/watch_display_seg7_decode.sv
// BCD digit to active-low seven-segment pattern.
// An invalid digit shows a dash.
module seg7_decode
  import watch_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       invalid,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (invalid) begin
      seg = SEG_DASH;
    end else begin
      case (bcd)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/watch_display.sv
// Time-of-day display driver: binary to BCD conversion and
// a four-digit multiplexed common-anode seven-segment scan.
module watch_display
  import watch_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic       userclock,
  input  logic       resetn,
  input  logic [7:0] n0and1,
  input  logic [6:0] n2and3,
  input  logic       sectick,
  input  logic       blank,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp
);

  localparam int PW = $clog2(SCAN_DIV);

  logic [PW-1:0] presc;
  logic          scantick;
  logic [1:0]    idx;
  logic [1:0]    idx_nx;
  logic          frame;
  logic          colon;
  logic          colon_nx;

  conv_state_t   state;
  logic [7:0]    work;
  logic [3:0]    tens;
  logic [3:0]    m_ones;
  logic [3:0]    m_tens;
  logic [6:0]    sh_hr;
  logic          minv_w;
  logic          hinv_w;
  bcd_t          bcd;
  logic          min_inv;
  logic          hr_inv;

  logic [3:0]    dig;
  logic          dig_inv;
  logic [6:0]    dig_seg;

  assign scantick = (presc == PW'(SCAN_DIV - 1));
  assign idx_nx   = idx + 2'd1;
  assign frame    = scantick && (idx == 2'd3);
  // a tick landing on the scan edge already counts
  assign colon_nx = colon ^ sectick;

  always_comb begin
    dig     = bcd.min_ones;
    dig_inv = min_inv;
    case (idx_nx)
      2'd1: begin
        dig     = bcd.min_tens;
        dig_inv = min_inv;
      end
      2'd2: begin
        dig     = bcd.hr_ones;
        dig_inv = hr_inv;
      end
      2'd3: begin
        dig     = bcd.hr_tens;
        dig_inv = hr_inv;
      end
      default: begin
        dig     = bcd.min_ones;
        dig_inv = min_inv;
      end
    endcase
  end

  seg7_decode u_dec (
    .bcd     (dig),
    .invalid (dig_inv),
    .seg     (dig_seg)
  );

  always_ff @(posedge userclock) begin
    if (!resetn) begin
      presc <= '0;
      idx   <= 2'd0;
      colon <= 1'b0;
      seg   <= SEG_BLANK;
      an    <= AN_OFF;
      dp    <= 1'b1;
    end else begin
      presc <= scantick ? '0 : presc + PW'(1);
      colon <= colon_nx;
      if (scantick) begin
        idx <= idx_nx;
        seg <= dig_seg;
        dp  <= !((idx_nx == 2'd2) && colon_nx);
      end
      if (blank) begin
        an <= AN_OFF;
      end else if (scantick) begin
        an <= an_code(idx_nx);
      end
    end
  end

  // out-of-range values skip the divider; the dash hides the digits
  always_ff @(posedge userclock) begin
    if (!resetn) begin
      state   <= IDLE;
      work    <= '0;
      tens    <= '0;
      m_ones  <= '0;
      m_tens  <= '0;
      sh_hr   <= '0;
      minv_w  <= 1'b0;
      hinv_w  <= 1'b0;
      bcd     <= '0;
      min_inv <= 1'b0;
      hr_inv  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (frame) begin
            work   <= n0and1;
            sh_hr  <= n2and3;
            tens   <= '0;
            minv_w <= (n0and1 >= 8'd60);
            hinv_w <= (n2and3 >= 7'd24);
            state  <= MIN;
          end
        end
        MIN: begin
          if (!minv_w && (work >= 8'd10)) begin
            work <= work - 8'd10;
            tens <= tens + 4'd1;
          end else begin
            m_ones <= work[3:0];
            m_tens <= tens;
            work   <= {1'b0, sh_hr};
            tens   <= '0;
            state  <= HR;
          end
        end
        HR: begin
          if (!hinv_w && (work >= 8'd10)) begin
            work <= work - 8'd10;
            tens <= tens + 4'd1;
          end else begin
            state <= DONE;
          end
        end
        DONE: begin
          bcd.hr_tens  <= tens;
          bcd.hr_ones  <= work[3:0];
          bcd.min_tens <= m_tens;
          bcd.min_ones <= m_ones;
          min_inv      <= minv_w;
          hr_inv       <= hinv_w;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
